sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Parametrised serial-in/parallel-out deserializer. Accepts one bit per clk
//   when si_valid is high and assembles WIDTH-bit words, MSB- or LSB-first.
//   Publishes each completed word on a held parallel register with a 1-cycle
//   po_valid strobe. Sits between a bit-serial source and word-wide logic.
// PARAMETERS
//   WIDTH      8  data bits per frame (>=2)
//   MSB_FIRST  1  1: first bit received lands in po[WIDTH-1]; 0: lands in po[0]
//   ODD_PARITY 0  parity sense when PARITY_CHK_EN is defined (0 even, 1 odd)
// PORTS
//   clk       in   1         rising-edge clock
//   rst       in   1         synchronous, active-high reset
//   si        in   1         serial data bit
//   si_valid  in   1         si is sampled on this clk edge
//   clr       in   1         sync soft clear: drop the partial frame
//   po        out  WIDTH     last completed word, held until the next one
//   po_valid  out  1         1-cycle pulse: po was updated on this edge
//   busy      out  1         partial frame in progress (bit_cnt != 0)
//   bit_cnt   out  CW        bits accepted in the current frame;
//                            CW = $clog2(FRAME+1), FRAME = WIDTH (+1 with parity)
//   par_err   out  1         parity mismatch on the last frame (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: sh, po, bit_cnt, po_valid, busy and par_err all go to 0. State is IDLE.
//   - FSM: IDLE (bit_cnt=0) -> SHIFT on the first accepted bit.
//     SHIFT -> IDLE on the edge that accepts bit FRAME-1; the counter wraps to 0.
//   - Shift on si_valid only:
//     MSB_FIRST=1: sh <= {sh[WIDTH-2:0], si}.
//     MSB_FIRST=0: sh <= {si, sh[WIDTH-1:1]}.
//   - Completion: on the edge that accepts the last data bit, po <= the shifted value
//     (including that bit), and po_valid=1 for exactly the following cycle.
//     Latency: last data bit edge -> po/po_valid valid 1 cycle later (registered).
//   - Back-to-back frames: a new frame may start on the very next cycle.
//     po_valid can be high on consecutive frames' boundaries with no gap.
//   - si_valid=0: hold sh and bit_cnt. Gaps of any length inside a frame are legal.
//   - clr (priority over si_valid): bit_cnt<=0, sh<=0, state IDLE.
//     po and par_err are retained. No po_valid is issued for the dropped frame.
//   - rst mid-frame: same as clr, and additionally po<=0 and par_err<=0.
//   - Simultaneous clr and last bit: clr wins and the frame is discarded.
//   - bit_cnt never exceeds FRAME-1.
// CONFIGURATION
//   PARITY_CHK_EN defined:
//   - FRAME = WIDTH+1. The extra trailing bit is the parity bit and is not shifted into po.
//   - State PARITY sits between SHIFT and IDLE. po updates and po_valid fires on the
//     parity-bit edge.
//   - par_err = (^data ^ pbit) != ODD_PARITY. It is updated together with po_valid.
//   PARITY_CHK_EN undefined:
//   - FRAME = WIDTH, there is no PARITY state, and par_err is tied 0.
// TESTING
//   1. WIDTH=4, MSB_FIRST=1: rst 3 cycles, then si=1,0,0,1 with si_valid held ->
//      po=4'b1001 with po_valid high 1 cycle after the 4th bit.
//   2. WIDTH=4, MSB_FIRST=0: si=1,1,0,0 -> po=4'b0011.
//   3. si_valid gaps of 3 idle cycles between bits -> identical po.
//      bit_cnt holds during the gaps. busy=1 throughout.
//   4. clr after 2 bits, then 4 fresh bits 0,1,1,1 -> po=4'b0111.
//      No po_valid for the dropped frame. The previous po is held until then.
//   5. Two frames back-to-back (1010 then 0101) -> po_valid high on 2 cycles
//      4 apart. po=1010 then po=0101.
//   6. PARITY_CHK_EN, WIDTH=4, even: data 1011 + pbit 1 -> par_err=0.
//      Data 1011 + pbit 0 -> par_err=1 with po=1011.
//      Undefined macro -> par_err stays 0.

Source files
------------

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer
// Brief    : Serial-in/parallel-out deserializer with MSB- or LSB-first framing.
//            Optional trailing parity bit check enabled by macro PARITY_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int ODD_PARITY = 0,
`ifdef PARITY_CHK_EN
   localparam int FRAME     = WIDTH + 1,
`else
   localparam int FRAME     = WIDTH,
`endif
   localparam int CW        = $clog2(FRAME + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   input  logic             si_valid,
   input  logic             clr,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   output logic             busy,
   output logic [CW-1:0]    bit_cnt,
   output logic             par_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic          ODD       = (ODD_PARITY != 0);

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_next;

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign sh_next = {sh[WIDTH-2:0], si};
      end else begin : g_lsb_first
         assign sh_next = {si, sh[WIDTH-1:1]};
      end
   endgenerate

   assign busy = (bit_cnt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         sh       <= '0;
         bit_cnt  <= '0;
         po       <= '0;
         po_valid <= 1'b0;
`ifdef PARITY_CHK_EN
         par_err  <= 1'b0;
`endif
      end else begin
         po_valid <= 1'b0;
         // clr outranks a simultaneous bit, so a frame finishing under clr is lost
         if (clr) begin
            state   <= S_IDLE;
            sh      <= '0;
            bit_cnt <= '0;
         end else if (si_valid) begin
            case (state)
               S_IDLE, S_SHIFT: begin
                  sh <= sh_next;
                  if (bit_cnt == LAST_DATA) begin
`ifdef PARITY_CHK_EN
                     bit_cnt <= bit_cnt + CNT_ONE;
                     state   <= S_PARITY;
`else
                     bit_cnt  <= '0;
                     state    <= S_IDLE;
                     po       <= sh_next;
                     po_valid <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CNT_ONE;
                     state   <= S_SHIFT;
                  end
               end
`ifdef PARITY_CHK_EN
               S_PARITY: begin
                  // parity bit is checked but never enters the data word
                  po       <= sh;
                  po_valid <= 1'b1;
                  par_err  <= (((^sh) ^ si) != ODD);
                  bit_cnt  <= '0;
                  sh       <= '0;
                  state    <= S_IDLE;
               end
`endif
               default: begin
                  state   <= S_IDLE;
                  sh      <= '0;
                  bit_cnt <= '0;
               end
            endcase
         end
      end
   end

`ifndef PARITY_CHK_EN
   logic unused_cfg;
   assign unused_cfg = ODD;
   assign par_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// Bench for sipo_deserializer: directed scenarios plus random traffic against a
// frame-level queue model, with MSB-first and LSB-first instances side by side.
module tb_sipo_deserializer;
   localparam int W = 4;
`ifdef PARITY_CHK_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif
   localparam int CW = $clog2(FRAME + 1);

   logic clk = 1'b0, rst = 1'b1, si = 1'b0, si_valid = 1'b0, clr = 1'b0;
   logic [W-1:0]  po_m, po_l;
   logic          pv_m, pv_l, busy_m, busy_l, pe_m, pe_l;
   logic [CW-1:0] cnt_m, cnt_l;

   int errors = 0;
   int checks = 0;

   bit           q[$];
   logic [W-1:0] exp_m = '0, exp_l = '0;
   logic         exp_pv = 1'b0, exp_pe = 1'b0;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1), .ODD_PARITY(0)) dut_m (
      .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .clr(clr),
      .po(po_m), .po_valid(pv_m), .busy(busy_m), .bit_cnt(cnt_m), .par_err(pe_m));

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0), .ODD_PARITY(0)) dut_l (
      .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .clr(clr),
      .po(po_l), .po_valid(pv_l), .busy(busy_l), .bit_cnt(cnt_l), .par_err(pe_l));

   always #5 clk = ~clk;

   // One clock: drive inputs, advance the frame model, sample 1 time unit after the edge
   task automatic cycle(input bit s, input bit v, input bit c);
      si = s; si_valid = v; clr = c;
      @(posedge clk);
      exp_pv = 1'b0;
      if (c) q.delete();
      else if (v) begin
         q.push_back(s);
         if (q.size() == FRAME) begin
            for (int i = 0; i < W; i++) begin
               exp_m[W-1-i] = q[i];
               exp_l[i]     = q[i];
            end
`ifdef PARITY_CHK_EN
            exp_pe = ((^exp_m) ^ q[W]) != 1'b0;
`endif
            exp_pv = 1'b1;
            q.delete();
         end
      end
      #1;
   endtask

   task automatic do_rst(input int n);
      rst = 1'b1; si_valid = 1'b0; clr = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      exp_m = '0; exp_l = '0; exp_pv = 1'b0; exp_pe = 1'b0;
   endtask

   // Sends bits[n-1] first, bits[0] last, with si_valid held
   task automatic send_bits(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cycle(bits[i], 1'b1, 1'b0);
   endtask

   // Data word MSB of the argument first, then (if enabled) a correct even parity bit
   task automatic send_word(input logic [W-1:0] w);
      send_bits({4'b0, w}, W);
`ifdef PARITY_CHK_EN
      cycle(^w, 1'b1, 1'b0);
`endif
   endtask

   task automatic test_reset();
      do_rst(3);
      checks++;
      if (po_m !== '0 || po_l !== '0 || pv_m !== 1'b0 || pv_l !== 1'b0 || cnt_m !== '0 ||
          busy_m !== 1'b0 || pe_m !== 1'b0 || cnt_l !== '0 || busy_l !== 1'b0)
         begin errors++; $display("FAIL reset: po_m=%b po_l=%b pv=%b cnt=%0d busy=%b pe=%b, want all zero",
                                 po_m, po_l, pv_m, cnt_m, busy_m, pe_m); end
   endtask

   task automatic test_msb_first();
      send_word(4'b1001);
      checks++;
      if (pv_m !== 1'b1 || po_m !== 4'b1001 || pv_l !== 1'b1 || po_l !== 4'b1001)
         begin errors++; $display("FAIL msb_1001: pv_m=%b po_m=%b po_l=%b, want 1 1001 1001", pv_m, po_m, po_l); end
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (pv_m !== 1'b0 || pv_l !== 1'b0 || po_m !== 4'b1001 || busy_m !== 1'b0)
         begin errors++; $display("FAIL pulse_width: pv_m=%b po_m=%b busy=%b, want 0 1001 0", pv_m, po_m, busy_m); end
   endtask

   task automatic test_lsb_first();
      send_word(4'b1100);
      checks++;
      if (po_l !== 4'b0011 || pv_l !== 1'b1)
         begin errors++; $display("FAIL lsb_0011: po_l=%b pv_l=%b, want 0011 1", po_l, pv_l); end
      checks++;
      if (po_m !== 4'b1100)
         begin errors++; $display("FAIL msb_1100: po_m=%b, want 1100", po_m); end
   endtask

   task automatic test_gaps();
      bit fb[$] = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef PARITY_CHK_EN
      fb.push_back(1'b0);
`endif
      for (int i = 0; i < FRAME; i++) begin
         cycle(fb[i], 1'b1, 1'b0);
         if (i != FRAME - 1) begin
            for (int g = 0; g < 3; g++) begin
               cycle(1'b1, 1'b0, 1'b0);
               checks++;
               if (cnt_m !== CW'(i + 1) || busy_m !== 1'b1 || pv_m !== 1'b0)
                  begin errors++; $display("FAIL gap_hold: cnt=%0d busy=%b pv=%b, want %0d 1 0",
                                          cnt_m, busy_m, pv_m, i + 1); end
            end
         end
      end
      checks++;
      if (pv_m !== 1'b1 || po_m !== 4'b1001 || po_l !== 4'b1001)
         begin errors++; $display("FAIL gap_word: pv=%b po_m=%b po_l=%b, want 1 1001 1001", pv_m, po_m, po_l); end
   endtask

   task automatic test_clr();
      send_bits(8'b11, 2);
      cycle(1'b1, 1'b1, 1'b1);
      checks++;
      if (pv_m !== 1'b0 || cnt_m !== '0 || busy_m !== 1'b0 || po_m !== 4'b1001)
         begin errors++; $display("FAIL clr_drop: pv=%b cnt=%0d busy=%b po=%b, want 0 0 0 1001",
                                 pv_m, cnt_m, busy_m, po_m); end
      send_word(4'b0111);
      checks++;
      if (pv_m !== 1'b1 || po_m !== 4'b0111 || po_l !== 4'b1110)
         begin errors++; $display("FAIL clr_next: pv=%b po_m=%b po_l=%b, want 1 0111 1110", pv_m, po_m, po_l); end
      // clr on the edge of the final bit discards the whole frame
      send_bits(8'b101, FRAME - 1);
      cycle(1'b0, 1'b1, 1'b1);
      checks++;
      if (pv_m !== 1'b0 || pv_l !== 1'b0 || po_m !== 4'b0111 || cnt_m !== '0)
         begin errors++; $display("FAIL clr_last: pv=%b po=%b cnt=%0d, want 0 0111 0", pv_m, po_m, cnt_m); end
   endtask

   task automatic test_back_to_back();
      int hits[$];
      logic [W-1:0] got[$];
      logic [7:0] bits;
`ifdef PARITY_CHK_EN
      bits = {2'b0, 4'b1010, 1'b0, 1'b0};
      bits = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int f = 0; f < 2; f++) begin
         bits = (f == 0) ? 8'h0A : 8'h05;
         for (int i = 0; i < FRAME; i++) begin
            if (i < W) cycle(bits[W-1-i], 1'b1, 1'b0);
            else       cycle(^bits, 1'b1, 1'b0);
            if (pv_m === 1'b1) begin hits.push_back(f * FRAME + i); got.push_back(po_m); end
         end
      end
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (hits.size() != 2)
         begin errors++; $display("FAIL b2b_count: pulses=%0d, want 2", hits.size()); end
      else begin
         checks++;
         if (hits[1] - hits[0] != FRAME || got[0] !== 4'b1010 || got[1] !== 4'b0101)
            begin errors++; $display("FAIL b2b_words: gap=%0d w0=%b w1=%b, want %0d 1010 0101",
                                    hits[1] - hits[0], got[0], got[1], FRAME); end
      end
   endtask

   task automatic test_rst_mid();
      send_bits(8'b10, 2);
      do_rst(1);
      checks++;
      if (po_m !== '0 || cnt_m !== '0 || busy_m !== 1'b0 || pv_m !== 1'b0 || pe_m !== 1'b0)
         begin errors++; $display("FAIL rst_mid: po=%b cnt=%0d busy=%b pv=%b pe=%b, want zeros",
                                 po_m, cnt_m, busy_m, pv_m, pe_m); end
   endtask

   task automatic test_parity();
`ifdef PARITY_CHK_EN
      send_bits(8'b10111, 5);
      checks++;
      if (pv_m !== 1'b1 || po_m !== 4'b1011 || pe_m !== 1'b0)
         begin errors++; $display("FAIL par_ok: pv=%b po=%b pe=%b, want 1 1011 0", pv_m, po_m, pe_m); end
      send_bits(8'b10110, 5);
      checks++;
      if (pv_m !== 1'b1 || po_m !== 4'b1011 || pe_m !== 1'b1)
         begin errors++; $display("FAIL par_bad: pv=%b po=%b pe=%b, want 1 1011 1", pv_m, po_m, pe_m); end
`else
      send_word(4'b1011);
      send_word(4'b0001);
      checks++;
      if (pe_m !== 1'b0 || pe_l !== 1'b0 || po_m !== 4'b0001)
         begin errors++; $display("FAIL par_tied: pe_m=%b pe_l=%b po=%b, want 0 0 0001", pe_m, pe_l, po_m); end
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom), ($urandom_range(9, 0) < 7), ($urandom_range(39, 0) == 0));
         checks++;
         if (pv_m !== exp_pv || pv_l !== exp_pv || po_m !== exp_m || po_l !== exp_l)
            begin errors++; $display("FAIL rnd_word@%0d: pv=%b/%b po=%b/%b, want %b %b/%b",
                                    n, pv_m, pv_l, po_m, po_l, exp_pv, exp_m, exp_l); end
         checks++;
         if (cnt_m !== CW'(q.size()) || cnt_l !== CW'(q.size()) || busy_m !== (q.size() != 0) ||
             pe_m !== exp_pe || pe_l !== exp_pe)
            begin errors++; $display("FAIL rnd_state@%0d: cnt=%0d busy=%b pe=%b, want %0d %b %b",
                                    n, cnt_m, busy_m, pe_m, q.size(), q.size() != 0, exp_pe); end
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_gaps();
      test_clr();
      test_back_to_back();
      test_rst_mid();
      test_parity();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
